// File: rtl/tlc_rr_if.sv
// Sensor and lamp bundle for the tlc_rr traffic light controller.
// The controller sits on the slave side; sensors and lamp drivers use master.
interface tlc_rr_if #(
   parameter int N_DIR = 2
);
   localparam int DIR_W = (N_DIR > 1) ? $clog2(N_DIR) : 1;

   logic [N_DIR-1:0]   car;
   logic               ped;
   logic [3*N_DIR-1:0] light;
   logic [1:0]         light_ped;
   logic [DIR_W-1:0]   active_dir;
   logic               ped_pending;
   logic [2:0]         state_o;

   modport master (
      output car, ped,
      input  light, light_ped, active_dir, ped_pending, state_o
   );

   modport slave (
      input  car, ped,
      output light, light_ped, active_dir, ped_pending, state_o
   );
endinterface

// File: rtl/tlc_rr.sv
// tlc_rr: N-approach traffic light controller with an internal phase timer,
// latched pedestrian requests and round-robin service of vehicle approaches.
// Every state, timer and latch update is gated by clk_en; the lamps are
// registered images of the next state so they never glitch.

// Configuration checks and the lamp safety invariant, kept apart from the
// controller logic.
module tlc_rr_chk #(
   parameter int N_DIR       = 2,
   parameter int TIMER_W     = 4,
   parameter int GREEN_MIN   = 4,
   parameter int GREEN_MAX   = 10,
   parameter int YELLOW_T    = 2,
   parameter int ALLRED_T    = 1,
   parameter int PED_WALK_T  = 5,
   parameter int PED_CLEAR_T = 3
) (
   input logic               clk,
   input logic               rst_n,
   input logic [3*N_DIR-1:0] light,
   input logic [1:0]         light_ped
);
   localparam int T_MAX = (1 << TIMER_W) - 1;

   if ((N_DIR < 2) || (N_DIR > 8)) begin : g_bad_ndir
      $error("tlc_rr: N_DIR must lie in 2..8");
   end
   if ((GREEN_MIN < 1) || (GREEN_MAX < GREEN_MIN) || (YELLOW_T < 1) || (ALLRED_T < 1)
       || (PED_WALK_T < 1) || (PED_CLEAR_T < 1)) begin : g_bad_dur
      $error("tlc_rr: phase durations out of range");
   end
   if ((GREEN_MAX > T_MAX) || (GREEN_MIN > T_MAX) || (YELLOW_T > T_MAX) || (ALLRED_T > T_MAX)
       || (PED_WALK_T > T_MAX) || (PED_CLEAR_T > T_MAX)) begin : g_bad_timer
      $error("tlc_rr: a phase duration does not fit in TIMER_W bits");
   end

   int   lit_cnt_s;
   logic safe_s;

   // Count lit approaches and decide whether the lamp pattern is safe.
   always_comb begin
      lit_cnt_s = 0;
      for (int i = 0; i < N_DIR; i++) begin
         if (light[3*i +: 3] != 3'b100) begin
            lit_cnt_s = lit_cnt_s + 1;
         end else begin
            lit_cnt_s = lit_cnt_s;
         end
      end
      if (lit_cnt_s > 1) begin
         safe_s = 1'b0;
      end else if ((lit_cnt_s == 1) && (light_ped != 2'b00)) begin
         safe_s = 1'b0;
      end else begin
         safe_s = 1'b1;
      end
   end

   a_lamp_safe: assert property (@(posedge clk) disable iff (!rst_n) safe_s)
      else $error("tlc_rr: lamp safety invariant violated");
endmodule

module tlc_rr #(
   parameter int N_DIR       = 2,
   parameter int TIMER_W     = 4,
   parameter int GREEN_MIN   = 4,
   parameter int GREEN_MAX   = 10,
   parameter int YELLOW_T    = 2,
   parameter int ALLRED_T    = 1,
   parameter int PED_WALK_T  = 5,
   parameter int PED_CLEAR_T = 3
) (
   input logic     clk,
   input logic     rst_n,
   input logic     clk_en,
   tlc_rr_if.slave bus
);
   localparam int DIR_W = (N_DIR > 1) ? $clog2(N_DIR) : 1;

   typedef enum logic [2:0] {
      ST_ALL_RED   = 3'd0,
      ST_GREEN     = 3'd1,
      ST_YELLOW    = 3'd2,
      ST_PED_WALK  = 3'd3,
      ST_PED_CLEAR = 3'd4
   } state_t;

   // Last elapsed value of each timed phase: the phase ends on this tick.
   localparam logic [TIMER_W-1:0] ALLRED_LAST = TIMER_W'(ALLRED_T - 1);
   localparam logic [TIMER_W-1:0] GMIN_LAST   = TIMER_W'(GREEN_MIN - 1);
   localparam logic [TIMER_W-1:0] GMAX_LAST   = TIMER_W'(GREEN_MAX - 1);
   localparam logic [TIMER_W-1:0] YELLOW_LAST = TIMER_W'(YELLOW_T - 1);
   localparam logic [TIMER_W-1:0] WALK_LAST   = TIMER_W'(PED_WALK_T - 1);
   localparam logic [TIMER_W-1:0] CLEAR_LAST  = TIMER_W'(PED_CLEAR_T - 1);
   localparam logic [TIMER_W-1:0] ELAPSED_SAT = {TIMER_W{1'b1}};
   localparam logic [TIMER_W-1:0] ELAPSED_ONE = TIMER_W'(1);
   localparam logic [DIR_W-1:0]   DIR_LAST    = DIR_W'(N_DIR - 1);

   state_t             state_r, state_nxt_s;
   logic [TIMER_W-1:0] elapsed_r, elapsed_nxt_s;
   logic [DIR_W-1:0]   dir_r, dir_nxt_s;
   logic               pend_r, pend_nxt_s;
   logic               hold_s;
   logic [3*N_DIR-1:0] light_r;
   logic [1:0]         light_ped_r;
   logic [2:0]         state_o_r;

   logic               other_demand_s;
   logic               own_s;
   logic               any_car_s;
   logic [DIR_W-1:0]   rr_pick_s;
   int                 dist_s;
   int                 best_dist_s;

   // Lamp image for a given state and granted approach.
   function automatic logic [3*N_DIR-1:0] lamps_f(input state_t st, input logic [DIR_W-1:0] dir);
      logic [3*N_DIR-1:0] lamps_v;
      lamps_v = {N_DIR{3'b100}};
      for (int i = 0; i < N_DIR; i++) begin
         if ((st == ST_GREEN) && (dir == DIR_W'(i))) begin
            lamps_v[3*i +: 3] = 3'b001;
         end else if ((st == ST_YELLOW) && (dir == DIR_W'(i))) begin
            lamps_v[3*i +: 3] = 3'b010;
         end else begin
            lamps_v[3*i +: 3] = 3'b100;
         end
      end
      return lamps_v;
   endfunction

   // Pedestrian lamp image for a given state.
   function automatic logic [1:0] ped_lamp_f(input state_t st);
      logic [1:0] lamp_v;
      case (st)
         ST_PED_WALK:  lamp_v = 2'b01;
         ST_PED_CLEAR: lamp_v = 2'b10;
         default:      lamp_v = 2'b00;
      endcase
      return lamp_v;
   endfunction

   // Demand seen by the granted approach: its own car bit versus everyone else.
   always_comb begin
      own_s          = bus.car[dir_r];
      other_demand_s = pend_r;
      for (int i = 0; i < N_DIR; i++) begin
         if (bus.car[i] && (dir_r != DIR_W'(i))) begin
            other_demand_s = 1'b1;
         end else begin
            other_demand_s = other_demand_s;
         end
      end
   end

   // Round-robin pick: nearest requesting approach after dir_r, dir_r itself last.
   always_comb begin
      any_car_s   = 1'b0;
      rr_pick_s   = dir_r;
      best_dist_s = N_DIR + 1;
      dist_s      = 0;
      for (int i = 0; i < N_DIR; i++) begin
         dist_s = i - int'(dir_r);
         if (dist_s <= 0) begin
            dist_s = dist_s + N_DIR;
         end else begin
            dist_s = dist_s;
         end
         if (bus.car[i] && (dist_s < best_dist_s)) begin
            best_dist_s = dist_s;
            any_car_s   = 1'b1;
            rr_pick_s   = DIR_W'(i);
         end else begin
            best_dist_s = best_dist_s;
         end
      end
   end

   // Next-state decision; only clk_en ticks may move the controller.
   always_comb begin
      state_nxt_s = state_r;
      dir_nxt_s   = dir_r;
      hold_s      = 1'b0;
      if (clk_en) begin
         case (state_r)
            ST_ALL_RED: begin
               if (elapsed_r == ALLRED_LAST) begin
                  if (pend_r) begin
                     state_nxt_s = ST_PED_WALK;
                  end else if (any_car_s) begin
                     state_nxt_s = ST_GREEN;
                     dir_nxt_s   = rr_pick_s;
                  end else begin
                     hold_s = 1'b1;
                  end
               end else begin
                  state_nxt_s = ST_ALL_RED;
               end
            end
            ST_GREEN: begin
               if ((elapsed_r >= GMIN_LAST) && other_demand_s
                   && (!own_s || (elapsed_r >= GMAX_LAST))) begin
                  state_nxt_s = ST_YELLOW;
               end else begin
                  state_nxt_s = ST_GREEN;
               end
            end
            ST_YELLOW: begin
               if (elapsed_r == YELLOW_LAST) begin
                  state_nxt_s = ST_ALL_RED;
               end else begin
                  state_nxt_s = ST_YELLOW;
               end
            end
            ST_PED_WALK: begin
               if (elapsed_r == WALK_LAST) begin
                  state_nxt_s = ST_PED_CLEAR;
               end else begin
                  state_nxt_s = ST_PED_WALK;
               end
            end
            ST_PED_CLEAR: begin
               if (elapsed_r == CLEAR_LAST) begin
                  state_nxt_s = ST_ALL_RED;
               end else begin
                  state_nxt_s = ST_PED_CLEAR;
               end
            end
            default: begin
               state_nxt_s = ST_ALL_RED;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Phase timer: restart on any state change, otherwise count ticks and saturate.
   always_comb begin
      if (state_nxt_s != state_r) begin
         elapsed_nxt_s = {TIMER_W{1'b0}};
      end else if (!clk_en || hold_s || (elapsed_r == ELAPSED_SAT)) begin
         elapsed_nxt_s = elapsed_r;
      end else begin
         elapsed_nxt_s = elapsed_r + ELAPSED_ONE;
      end
   end

   // Pedestrian latch: cleared on walk entry, deaf while walking, set otherwise.
   always_comb begin
      if (!clk_en) begin
         pend_nxt_s = pend_r;
      end else if (state_nxt_s == ST_PED_WALK) begin
         pend_nxt_s = 1'b0;
      end else if (bus.ped && (state_r != ST_PED_WALK)) begin
         pend_nxt_s = 1'b1;
      end else begin
         pend_nxt_s = pend_r;
      end
   end

   // Controller registers; the outputs are registered images of the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_ALL_RED;
         elapsed_r   <= {TIMER_W{1'b0}};
         dir_r       <= DIR_LAST;
         pend_r      <= 1'b0;
         light_r     <= {N_DIR{3'b100}};
         light_ped_r <= 2'b00;
         state_o_r   <= 3'd0;
      end else begin
         state_r     <= state_nxt_s;
         elapsed_r   <= elapsed_nxt_s;
         dir_r       <= dir_nxt_s;
         pend_r      <= pend_nxt_s;
         light_r     <= lamps_f(state_nxt_s, dir_nxt_s);
         light_ped_r <= ped_lamp_f(state_nxt_s);
         state_o_r   <= state_nxt_s;
      end
   end

   assign bus.light       = light_r;
   assign bus.light_ped   = light_ped_r;
   assign bus.active_dir  = dir_r;
   assign bus.ped_pending = pend_r;
   assign bus.state_o     = state_o_r;

   tlc_rr_chk #(
      .N_DIR       (N_DIR),
      .TIMER_W     (TIMER_W),
      .GREEN_MIN   (GREEN_MIN),
      .GREEN_MAX   (GREEN_MAX),
      .YELLOW_T    (YELLOW_T),
      .ALLRED_T    (ALLRED_T),
      .PED_WALK_T  (PED_WALK_T),
      .PED_CLEAR_T (PED_CLEAR_T)
   ) u_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .light     (light_r),
      .light_ped (light_ped_r)
   );
endmodule

// File: tb/tb_tlc_rr.sv
// Bench for tlc_rr: a 2-approach and a 4-approach instance run side by side
// against a tick-level reference model that follows the phase rules directly.
module tb_tlc_rr;
   localparam int GMIN = 4, GMAX = 10, YEL = 2, ALLR = 1, WALK = 5, CLR = 3;
   localparam int P_AR = 0, P_G = 1, P_Y = 2, P_W = 3, P_C = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic en2, en4;

   tlc_rr_if #(.N_DIR(2)) bus2 ();
   tlc_rr_if #(.N_DIR(4)) bus4 ();

   tlc_rr #(.N_DIR(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .clk_en(en2), .bus(bus2));
   tlc_rr #(.N_DIR(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .clk_en(en4), .bus(bus4));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // reference model per instance: phase, ticks spent in it, granted dir, latch
   int nd [2] = '{2, 4};
   int ph [2];
   int tk [2];
   int dir [2];
   int pend [2];

   // DUT4 grant tracking
   int g4_prev = -1;
   bit rec4 = 1'b0;
   int grants4 [$];
   int bad_green4 = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         if (n_errors <= 40)
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         ph[m] = P_AR; tk[m] = 0; dir[m] = nd[m] - 1; pend[m] = 0;
      end
   endtask

   task automatic model_tick(input int m, input bit en, input logic [7:0] car, input bit ped);
      int n, tn, nxt, ndir, idx;
      bit other, own;
      if (!en) return;
      n = nd[m]; tn = tk[m] + 1; nxt = ph[m]; ndir = dir[m];
      other = (pend[m] != 0);
      for (int i = 0; i < n; i++)
         if (i != dir[m] && car[i]) other = 1'b1;
      idx = dir[m];
      own = car[idx];
      case (ph[m])
         P_AR: if (tn >= ALLR) begin
            if (pend[m] != 0) nxt = P_W;
            else begin
               for (int k = 1; k <= n; k++) begin
                  idx = (dir[m] + k) % n;
                  if (car[idx]) begin nxt = P_G; ndir = idx; break; end
               end
            end
         end
         P_G: if (tn >= GMIN && other && (!own || tn >= GMAX)) nxt = P_Y;
         P_Y: if (tn >= YEL) nxt = P_AR;
         P_W: if (tn >= WALK) nxt = P_C;
         P_C: if (tn >= CLR) nxt = P_AR;
         default: nxt = P_AR;
      endcase
      if (nxt == P_W) pend[m] = 0;
      else if (ped && ph[m] != P_W) pend[m] = 1;
      tk[m] = (nxt != ph[m]) ? 0 : tn;
      ph[m] = nxt;
      dir[m] = ndir;
   endtask

   function automatic logic [31:0] exp_lamps(input int m);
      logic [31:0] l = 32'd0;
      for (int i = 0; i < nd[m]; i++) begin
         if (ph[m] == P_G && i == dir[m]) l[3*i +: 3] = 3'b001;
         else if (ph[m] == P_Y && i == dir[m]) l[3*i +: 3] = 3'b010;
         else l[3*i +: 3] = 3'b100;
      end
      return l;
   endfunction

   function automatic logic [31:0] exp_ped(input int m);
      return (ph[m] == P_W) ? 32'd1 : (ph[m] == P_C) ? 32'd2 : 32'd0;
   endfunction

   function automatic logic [31:0] is_safe(input logic [23:0] l, input int n, input logic [1:0] lp);
      int lit = 0;
      for (int i = 0; i < n; i++) if (l[3*i +: 3] != 3'b100) lit++;
      return ((lit <= 1) && !(lit == 1 && lp != 2'b00)) ? 32'd1 : 32'd0;
   endfunction

   task automatic compare_all();
      check_eq("light2", 32'(bus2.light), exp_lamps(0));
      check_eq("ped2", 32'(bus2.light_ped), exp_ped(0));
      check_eq("dir2", 32'(bus2.active_dir), 32'(dir[0]));
      check_eq("pend2", 32'(bus2.ped_pending), 32'(pend[0]));
      check_eq("state2", 32'(bus2.state_o), 32'(ph[0]));
      check_eq("safe2", is_safe(24'(bus2.light), 2, bus2.light_ped), 32'd1);
      check_eq("light4", 32'(bus4.light), exp_lamps(1));
      check_eq("ped4", 32'(bus4.light_ped), exp_ped(1));
      check_eq("dir4", 32'(bus4.active_dir), 32'(dir[1]));
      check_eq("pend4", 32'(bus4.ped_pending), 32'(pend[1]));
      check_eq("state4", 32'(bus4.state_o), 32'(ph[1]));
      check_eq("safe4", is_safe(24'(bus4.light), 4, bus4.light_ped), 32'd1);
   endtask

   task automatic step();
      int g_now;
      @(posedge clk);
      if (rst_n) begin
         model_tick(0, en2, {6'd0, bus2.car}, bus2.ped);
         model_tick(1, en4, {4'd0, bus4.car}, bus4.ped);
      end else begin
         model_reset();
      end
      #1;
      cyc++;
      compare_all();
      g_now = -1;
      for (int i = 0; i < 4; i++) if (bus4.light[3*i +: 3] == 3'b001) g_now = i;
      if (rec4 && g_now >= 0 && g4_prev < 0) grants4.push_back(g_now);
      if (rec4 && (g_now == 0 || g_now == 2)) bad_green4++;
      g4_prev = g_now;
   endtask

   task automatic wait_phase(input int m, input int p, input int d, input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (ph[m] == p && (d < 0 || dir[m] == d)) found = 1'b1;
         else step();
      end
      check_eq(tag, 32'(found), 32'd1);
   endtask

   initial begin
      int exp_order [4];
      bit seen;
      exp_order = '{3, 1, 3, 1};
      rst_n = 1'b0; en2 = 1'b1; en4 = 1'b1;
      bus2.car = 2'b01; bus2.ped = 1'b0; bus4.car = 4'b0000; bus4.ped = 1'b0;
      model_reset();
      repeat (3) step();
      #4 rst_n = 1'b1;

      // dir0 alone: one all-red tick, then rest in green
      repeat (25) step();
      // both approaches: GREEN_MAX alternation
      bus2.car = 2'b11;
      repeat (40) step();
      // pedestrian pulse at the start of dir1 green
      bus2.car = 2'b10;
      wait_phase(0, P_G, 1, "wait_g1");
      bus2.ped = 1'b1;
      step();
      bus2.ped = 1'b0;
      repeat (30) step();
      // slowed tick rate
      bus2.car = 2'b11;
      for (int i = 0; i < 200; i++) begin
         en2 = (i % 4 == 3);
         step();
      end
      en2 = 1'b1;
      // asynchronous reset in the middle of yellow
      wait_phase(0, P_Y, -1, "wait_yel");
      #3 rst_n = 1'b0;
      #1;
      check_eq("rst_light2", 32'(bus2.light), 32'h24);
      check_eq("rst_ped2", 32'(bus2.light_ped), 32'd0);
      check_eq("rst_state2", 32'(bus2.state_o), 32'd0);
      check_eq("rst_light4", 32'(bus4.light), 32'h924);
      model_reset();
      #2 rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step();
         if (bus2.light[2:0] == 3'b001 || bus2.light[5:3] == 3'b001) begin
            seen = 1'b1;
            check_eq("first_after_rst", 32'(bus2.active_dir), 32'd0);
         end
      end
      check_eq("green_after_rst", 32'(seen), 32'd1);

      // four approaches, two competing
      bus4.car = 4'b0010;
      wait_phase(1, P_G, 1, "wait_g4_1");
      bus4.car = 4'b1010;
      rec4 = 1'b1;
      repeat (60) step();
      rec4 = 1'b0;
      check_eq("grant_cnt4", 32'(grants4.size() >= 4), 32'd1);
      for (int i = 0; i < 4; i++)
         if (i < grants4.size()) check_eq("grant_order4", 32'(grants4[i]), 32'(exp_order[i]));
      check_eq("green_0_2", 32'(bad_green4), 32'd0);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) bus2.car = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) bus4.car = 4'($urandom_range(0, 15));
         bus2.ped = ($urandom_range(0, 15) == 0);
         bus4.ped = ($urandom_range(0, 15) == 0);
         en2 = ($urandom_range(0, 3) != 0);
         en4 = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "tb_tlc_rr watchdog expired");
   end
endmodule
